// File: rtl/fetch_unit.sv
// fetch_unit - instruction fetch stage.
//
// Owns the program counter, issues in-order instruction memory reads (at most
// one outstanding), and buffers returned instructions in a small shift-register
// FIFO whose head drives the IF/ID pipeline register.  A taken branch flushes
// the FIFO, redirects the PC and discards any response still in flight.
//
// Parameters:
//   RESET_PC  fetch address loaded on reset
//   DEPTH     instruction FIFO entries (>= 2, power of two)
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   ifid_write        1 = IF/ID consumes the head this cycle, 0 = stall
//   branch_taken      redirect request from EX
//   branch_target     redirect address (bits [1:0] ignored)
//   imem_req          read request, accepted by memory in the same cycle
//   imem_addr         word-aligned read address (0 when no request)
//   imem_rvalid       in-order response strobe
//   imem_rdata        response instruction
//   PC_out            PC of FIFO head (0 when empty)
//   instruction_out   instruction of FIFO head (bubble pattern when empty)
//   fetch_valid       FIFO non-empty
//
// Build option: define FETCH_NOP_BUBBLE_EN to present addi x0,x0,0
// (32'h00000013) instead of 32'h0 on instruction_out while the FIFO is empty.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifid_write,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        fetch_valid
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_CNT = {CW{1'b0}};
`ifdef FETCH_NOP_BUBBLE_EN
  localparam logic [31:0]   BUBBLE_INSTR = 32'h0000_0013;
`else
  localparam logic [31:0]   BUBBLE_INSTR = 32'h0000_0000;
`endif

  // ISSUE: nothing outstanding; WAIT: live request outstanding;
  // DRAIN: outstanding response belongs to a flushed path.
  typedef enum logic [1:0] {ISSUE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_r, state_s;
  logic [63:0]   fetch_pc_r, fetch_pc_s;
  logic [63:0]   req_pc_r, req_pc_s;
  logic [CW-1:0] count_r, count_s;
  logic [CW-1:0] wr_idx_s, after_push_s;
  logic [63:0]   pc_q_r    [DEPTH];
  logic [31:0]   instr_q_r [DEPTH];
  logic [63:0]   shift_pc_s    [DEPTH];
  logic [31:0]   shift_instr_s [DEPTH];
  logic [63:0]   pc_q_s    [DEPTH];
  logic [31:0]   instr_q_s [DEPTH];
  logic          valid_r;
  logic          req_s, push_s, pop_s;
  logic          unused_target_bits_s;

  // Low target bits are cleared on redirect and never looked at.
  assign unused_target_bits_s = ^branch_target[1:0];

  assign pop_s        = ifid_write & (count_r != ZERO_CNT);
  // Slot the new entry lands in once this cycle's pop has shifted the queue.
  assign wr_idx_s     = count_r - {{(CW-1){1'b0}}, pop_s};
  assign after_push_s = wr_idx_s + {{(CW-1){1'b0}}, 1'b1};

  // Fetch control: redirect has priority; otherwise issue/response handling.
  // The follow-on request is raised in the response cycle so a 1-cycle
  // memory sustains one fetch per clock.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    req_pc_s   = req_pc_r;
    req_s      = 1'b0;
    push_s     = 1'b0;
    if (branch_taken) begin
      fetch_pc_s = {branch_target[63:2], 2'b00};
      if ((state_r != ISSUE) && !imem_rvalid) begin
        state_s = DRAIN;
      end else begin
        state_s = ISSUE;
      end
    end else begin
      case (state_r)
        ISSUE: begin
          if (count_r < FULL_CNT) begin
            req_s = 1'b1;
          end else begin
            req_s = 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            push_s = 1'b1;
            if (after_push_s < FULL_CNT) begin
              req_s = 1'b1;
            end else begin
              state_s = ISSUE;
            end
          end else begin
            state_s = WAIT;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state_s = ISSUE;
          end else begin
            state_s = DRAIN;
          end
        end
        default: begin
          state_s = ISSUE;
        end
      endcase
      if (req_s) begin
        state_s    = WAIT;
        req_pc_s   = fetch_pc_r;
        fetch_pc_s = fetch_pc_r + 64'd4;
      end else begin
        req_pc_s   = req_pc_r;
        fetch_pc_s = fetch_pc_r;
      end
    end
  end

  // FIFO pop/flush: entry 0 is the head; vacated entries take the empty
  // pattern so the head register is directly the output value.
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (branch_taken) begin
        shift_pc_s[i]    = 64'h0;
        shift_instr_s[i] = BUBBLE_INSTR;
      end else if (pop_s) begin
        shift_pc_s[i]    = pc_q_r[i+1];
        shift_instr_s[i] = instr_q_r[i+1];
      end else begin
        shift_pc_s[i]    = pc_q_r[i];
        shift_instr_s[i] = instr_q_r[i];
      end
    end
    if (branch_taken || pop_s) begin
      shift_pc_s[DEPTH-1]    = 64'h0;
      shift_instr_s[DEPTH-1] = BUBBLE_INSTR;
    end else begin
      shift_pc_s[DEPTH-1]    = pc_q_r[DEPTH-1];
      shift_instr_s[DEPTH-1] = instr_q_r[DEPTH-1];
    end
  end

  // FIFO push and occupancy update.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (wr_idx_s == CW'(i))) begin
        pc_q_s[i]    = req_pc_r;
        instr_q_s[i] = imem_rdata;
      end else begin
        pc_q_s[i]    = shift_pc_s[i];
        instr_q_s[i] = shift_instr_s[i];
      end
    end
    if (branch_taken) begin
      count_s = ZERO_CNT;
    end else begin
      count_s = count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
    end
  end

  // State, FIFO and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ISSUE;
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= 64'h0;
      count_r    <= ZERO_CNT;
      valid_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q_r[i]    <= 64'h0;
        instr_q_r[i] <= BUBBLE_INSTR;
      end
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      req_pc_r   <= req_pc_s;
      count_r    <= count_s;
      valid_r    <= (count_s != ZERO_CNT);
      for (int i = 0; i < DEPTH; i++) begin
        pc_q_r[i]    <= pc_q_s[i];
        instr_q_r[i] <= instr_q_s[i];
      end
    end
  end

  assign imem_req        = req_s & ~reset;
  assign imem_addr       = imem_req ? fetch_pc_r : 64'h0;
  assign PC_out          = pc_q_r[0];
  assign instruction_out = instr_q_r[0];
  assign fetch_valid     = valid_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based reference model and a variable-latency memory model.
module tb_fetch_unit;
  localparam int          DEPTH   = 2;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
`ifdef FETCH_NOP_BUBBLE_EN
  localparam logic [31:0] EXP_BUBBLE = 32'h0000_0013;
`else
  localparam logic [31:0] EXP_BUBBLE = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset, ifid_write, branch_taken, imem_req, imem_rvalid, fetch_valid;
  logic [63:0] branch_target, imem_addr, PC_out;
  logic [31:0] imem_rdata, instruction_out;

  logic        w_ifid, w_br, w_req, w_rvalid, w_valid;
  logic [63:0] w_tgt, w_addr, w_pc;
  logic [31:0] w_rdata, w_ins;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ifid_write(ifid_write), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .PC_out(PC_out),
    .instruction_out(instruction_out), .fetch_valid(fetch_valid));

  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .reset(reset), .ifid_write(w_ifid), .branch_taken(w_br),
    .branch_target(w_tgt), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata), .PC_out(w_pc),
    .instruction_out(w_ins), .fetch_valid(w_valid));

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int lat = 1;
  int last_due = 0;

  typedef struct packed {logic [63:0] pc; logic [31:0] ins;} ent_t;
  typedef struct packed {logic [63:0] addr; int due;} mreq_t;
  ent_t  mq[$];     // reference FIFO contents
  mreq_t memq[$];   // memory requests awaiting response

  logic [63:0] m_fetch_pc, m_out_addr;
  bit          m_out, m_stale, m_init;

  logic        cap_req, cap_valid, cap_rvalid;
  logic [63:0] cap_addr, cap_pc;
  logic [31:0] cap_ins;

  logic        w_pend;
  logic [63:0] w_addrs[$];
  logic [63:0] exp_pop;

  function automatic logic [31:0] data_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // One clock cycle: drive, compare against the model, advance model and memory.
  task automatic step(input bit rst, input bit wr, input bit br, input logic [63:0] tgt);
    bit          pop_e, exp_req, exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_ins;
    int          due;
    reset = rst; ifid_write = wr; branch_taken = br; branch_target = tgt;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = data_of(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    w_rvalid = w_pend; w_rdata = 32'h0000_0013;
    #1;
    pop_e = wr && (mq.size() > 0);
    if (rst || br) exp_req = 1'b0;
    else if (!m_out) exp_req = (mq.size() < DEPTH);
    else if (m_stale || !imem_rvalid) exp_req = 1'b0;
    else exp_req = ((mq.size() + 1 - (pop_e ? 1 : 0)) < DEPTH);
    exp_valid = (mq.size() > 0);
    exp_pc    = exp_valid ? mq[0].pc : 64'h0;
    exp_ins   = exp_valid ? mq[0].ins : EXP_BUBBLE;
    cap_req = imem_req; cap_addr = imem_addr; cap_valid = fetch_valid;
    cap_pc = PC_out; cap_ins = instruction_out; cap_rvalid = imem_rvalid;
    if (m_init) begin
      check("fetch_valid", fetch_valid, exp_valid);
      check("PC_out", PC_out, exp_pc);
      check("instruction_out", instruction_out, exp_ins);
      check("imem_req", imem_req, exp_req);
      if (exp_req) check("imem_addr", imem_addr, m_fetch_pc);
    end
    // memory model
    if (imem_rvalid) void'(memq.pop_front());
    if (imem_req === 1'b1) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      memq.push_back('{addr: imem_addr, due: due});
      last_due = due;
    end
    // wrap instance: 1-cycle memory, record first two addresses
    if (!rst && w_req === 1'b1 && w_addrs.size() < 2) w_addrs.push_back(w_addr);
    w_pend = (w_req === 1'b1) && !rst;
    // reference model
    if (rst) begin
      mq.delete(); m_fetch_pc = 64'h0; m_out = 1'b0; m_stale = 1'b0; m_init = 1'b1;
    end else if (br) begin
      mq.delete();
      m_fetch_pc = {tgt[63:2], 2'b00};
      if (imem_rvalid) m_out = 1'b0;
      m_stale = m_out;
    end else begin
      if (pop_e) void'(mq.pop_front());
      if (m_out && imem_rvalid) begin
        if (!m_stale) mq.push_back('{pc: m_out_addr, ins: imem_rdata});
        m_out = 1'b0; m_stale = 1'b0;
      end
      if (exp_req) begin
        m_out = 1'b1; m_stale = 1'b0; m_out_addr = m_fetch_pc; m_fetch_pc = m_fetch_pc + 64'd4;
      end
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic step_track(input bit wr);
    step(1'b0, wr, 1'b0, 64'h0);
    if (cap_valid === 1'b1 && wr) begin
      check("pop_order", cap_pc, exp_pop);
      exp_pop = exp_pop + 64'd4;
    end
  endtask

  initial begin
    logic        r_req[7], r_valid[7];
    logic [63:0] r_addr[7], r_pc[7];
    bit          found, saw_rv;
    m_init = 1'b0; m_out = 1'b0; m_stale = 1'b0; w_pend = 1'b0; exp_pop = 64'h0;
    w_ifid = 1'b1; w_br = 1'b0; w_tgt = 64'h0;

    // reset and reset-state literals
    step(1'b1, 1'b1, 1'b0, 64'h0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check("rst_valid", cap_valid, 64'h0);
    check("rst_pc", cap_pc, 64'h0);
    check("rst_ins", cap_ins, EXP_BUBBLE);
    check("rst_req", cap_req, 64'h0);
    check("rst_addr", cap_addr, 64'h0);

    // streaming with 1-cycle memory
    lat = 1;
    for (int k = 1; k <= 6; k++) begin
      step_track(1'b1);
      r_req[k] = cap_req; r_addr[k] = cap_addr; r_valid[k] = cap_valid; r_pc[k] = cap_pc;
    end
    check("s_req1", r_req[1], 64'h1);  check("s_addr1", r_addr[1], 64'h0);
    check("s_req2", r_req[2], 64'h1);  check("s_addr2", r_addr[2], 64'h4);
    check("s_req3", r_req[3], 64'h1);  check("s_addr3", r_addr[3], 64'h8);
    check("s_valid2", r_valid[2], 64'h0);
    check("s_valid3", r_valid[3], 64'h1);
    check("s_pc3", r_pc[3], 64'h0);
    check("s_pc4", r_pc[4], 64'h4);
    check("s_pc5", r_pc[5], 64'h8);

    // stall: FIFO fills, requests stop, head held
    for (int k = 1; k <= 5; k++) begin
      step_track(1'b0);
      check("stall_valid", cap_valid, 64'h1);
      check("stall_head", cap_pc, exp_pop);
    end
    check("stall_req_dropped", cap_req, 64'h0);
    for (int k = 0; k < 8; k++) step_track(1'b1);

    // redirect with request outstanding, 3-cycle memory
    lat = 3;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step_track(1'b1);
      found = (cap_req === 1'b1);
    end
    check("br_req_seen", found, 64'h1);
    step(1'b0, 1'b1, 1'b1, 64'h103);
    found = 1'b0; saw_rv = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0);
      if (cap_req === 1'b1) begin
        found = 1'b1;
        check("br_target_addr", cap_addr, 64'h100);
        check("br_drained_first", saw_rv, 64'h1);
      end
      if (cap_rvalid === 1'b1) saw_rv = 1'b1;
    end
    check("br_req_timeout", found, 64'h1);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0);
      if (cap_valid === 1'b1) begin
        found = 1'b1;
        check("br_first_pc", cap_pc, 64'h100);
        check("br_first_ins", cap_ins, {32'h0, data_of(64'h100)});
      end
    end
    check("br_valid_timeout", found, 64'h1);

    // redirect coinciding with response and pop
    lat = 1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (memq.size() > 0 && memq[0].due <= cyc && mq.size() > 0) found = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 64'h0);
    end
    check("co_setup", found, 64'h1);
    step(1'b0, 1'b1, 1'b1, 64'h2000);
    check("co_rvalid", cap_rvalid, 64'h1);
    check("co_popped", cap_valid, 64'h1);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    check("co_empty", cap_valid, 64'h0);
    check("co_req", cap_req, 64'h1);
    check("co_addr", cap_addr, 64'h2000);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      lat = $urandom_range(1, 3);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), {$urandom, $urandom});
    end

    // empty FIFO after reset shows bubble
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("empty_ins", cap_ins, EXP_BUBBLE);
    check("empty_pc", cap_pc, 64'h0);
    check("empty_valid", cap_valid, 64'h0);

    // PC wrap on the second instance
    if (w_addrs.size() >= 2) begin
      check("wrap_addr0", w_addrs[0], WRAP_PC);
      check("wrap_addr1", w_addrs[1], 64'h0);
    end else begin
      check("wrap_req_count", w_addrs.size(), 64'd2);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
